// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the core load/store
// path and a word-wide backing memory; a miss stalls the core while lines move one word per beat.
module data_cache #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int BEAT_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [SETS-1:0]     valid_q, dirty_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [31:0]         data_q [SETS][LINE_WORDS];

    logic [BEAT_W-1:0]   req_off;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                access, hit, store_hit, refill_wr, last_beat;
    logic                unused_addr_bits;

    assign req_off          = (OFF_W > 0) ? cpu_addr[2 +: BEAT_W] : '0;
    assign req_idx          = cpu_addr[2+OFF_W +: IDX_W];
    assign req_tag          = cpu_addr[31 -: TAG_W];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign access    = cpu_re || cpu_we;
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign last_beat = (beat_q == LAST_BEAT);
    assign cpu_rdata = data_q[req_idx][req_off];

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        store_hit = 1'b0;
        refill_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        store_hit = cpu_we;
                    end else begin
                        stall   = 1'b1;
                        beat_d  = '0;
                        state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[req_idx], req_idx, {(OFF_W+2){1'b0}}} | (32'(beat_q) << 2);
                mem_wdata = data_q[req_idx][beat_q];
                if (mem_ack) begin
                    if (last_beat) begin
                        state_d = REFILL;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, {(OFF_W+2){1'b0}}} | (32'(beat_q) << 2);
                if (mem_ack) begin
                    refill_wr = 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state; a refill in progress keeps the line invalid until its last word lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (store_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (refill_wr) begin
                valid_q[req_idx] <= last_beat;
                dirty_q[req_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_be[b]) begin
                    data_q[req_idx][req_off][8*b +: 8] <= cpu_wdata[8*b +: 8];
                end
            end
        end
        if (refill_wr) begin
            data_q[req_idx][beat_q] <= mem_rdata;
            if (last_beat) begin
                tag_q[req_idx] <= req_tag;
            end
        end
    end

endmodule
